// File: rtl/tl_lamp_sequencer.sv
// tl_lamp_sequencer: fixed-cycle traffic light phase sequencer.
// Each phase entry writes the new lamp pattern to six external SR latches
// through a four-cycle write sequence (present, strobe, hold, release).
// A pedestrian request may cut a green phase short once its minimum has run.
module tl_lamp_sequencer #(
  parameter int G_TICKS     = 8,
  parameter int Y_TICKS     = 3,
  parameter int R_TICKS     = 2,
  parameter int MIN_G_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ped_req,
  output logic [5:0] lamp_s,
  output logic [5:0] lamp_r,
  output logic       lamp_en,
  output logic [2:0] phase,
  output logic       busy
);

  localparam int MAX_D = (G_TICKS > Y_TICKS) ?
                         ((G_TICKS > R_TICKS) ? G_TICKS : R_TICKS) :
                         ((Y_TICKS > R_TICKS) ? Y_TICKS : R_TICKS);
  localparam int CW = $clog2(MAX_D + 1);

  localparam logic [CW-1:0] G_D = CW'(G_TICKS);
  localparam logic [CW-1:0] Y_D = CW'(Y_TICKS);
  localparam logic [CW-1:0] R_D = CW'(R_TICKS);
  // A green tick may force expiry once the count, after this tick, shows
  // MIN_G_TICKS elapsed: G - (cnt - 1) >= MIN  <=>  cnt <= G - MIN + 1.
  localparam logic [CW-1:0] CUT_MAX = CW'(G_TICKS - MIN_G_TICKS + 1);

  typedef enum logic [2:0] {
    PH_NS_G = 3'd0,
    PH_NS_Y = 3'd1,
    PH_AR1  = 3'd2,
    PH_EW_G = 3'd3,
    PH_EW_Y = 3'd4,
    PH_AR2  = 3'd5
  } phase_t;

  // SQ_START exists only to launch the AR2 write on the first edge after reset.
  typedef enum logic [2:0] {
    SQ_START = 3'd0,
    SQ_W0    = 3'd1,
    SQ_W1    = 3'd2,
    SQ_W2    = 3'd3,
    SQ_IDLE  = 3'd4
  } seq_t;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_NS_G: next_phase = PH_NS_Y;
      PH_NS_Y: next_phase = PH_AR1;
      PH_AR1:  next_phase = PH_EW_G;
      PH_EW_G: next_phase = PH_EW_Y;
      PH_EW_Y: next_phase = PH_AR2;
      default: next_phase = PH_NS_G;
    endcase
  endfunction

  function automatic logic [CW-1:0] phase_dur(input phase_t p);
    case (p)
      PH_NS_G, PH_EW_G: phase_dur = G_D;
      PH_NS_Y, PH_EW_Y: phase_dur = Y_D;
      default:          phase_dur = R_D;
    endcase
  endfunction

  // Bit order: 0 NS_R, 1 NS_Y, 2 NS_G, 3 EW_R, 4 EW_Y, 5 EW_G.
  function automatic logic [5:0] phase_pattern(input phase_t p);
    case (p)
      PH_NS_G: phase_pattern = 6'b001_100;
      PH_NS_Y: phase_pattern = 6'b001_010;
      PH_EW_G: phase_pattern = 6'b100_001;
      PH_EW_Y: phase_pattern = 6'b010_001;
      default: phase_pattern = 6'b001_001;
    endcase
  endfunction

  phase_t        phase_reg, phase_next;
  seq_t          seq_reg, seq_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          ped_pend_reg, ped_pend_next;

  logic          expired;
  logic          is_green;
  logic [5:0]    pattern;
  phase_t        upcoming;

  // State registers; reset parks in AR2 with the clearance count loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg    <= PH_AR2;
      seq_reg      <= SQ_START;
      cnt_reg      <= R_D;
      ped_pend_reg <= 1'b0;
    end else begin
      phase_reg    <= phase_next;
      seq_reg      <= seq_next;
      cnt_reg      <= cnt_next;
      ped_pend_reg <= ped_pend_next;
    end
  end

  // Next-state: write-sequence stepping, phase advance, tick counting, ped flag.
  always_comb begin
    phase_next    = phase_reg;
    seq_next      = seq_reg;
    cnt_next      = cnt_reg;
    ped_pend_next = ped_pend_reg | ped_req;

    expired  = (cnt_reg == '0);
    is_green = (phase_reg == PH_NS_G) || (phase_reg == PH_EW_G);
    upcoming = next_phase(phase_reg);

    case (seq_reg)
      SQ_START: seq_next = SQ_W0;
      SQ_W0:    seq_next = SQ_W1;
      SQ_W1:    seq_next = SQ_W2;
      SQ_W2:    seq_next = SQ_IDLE;
      default:  seq_next = SQ_IDLE;
    endcase

    if (seq_reg == SQ_IDLE && expired) begin
      // Advance only when the latches are free; an expiry during a write
      // simply waits here with the count stuck at zero, so ticks are moot.
      phase_next = upcoming;
      cnt_next   = phase_dur(upcoming);
      seq_next   = SQ_W0;
      // Clear wins over a request arriving on the very entry edge.
      if (upcoming == PH_AR1 || upcoming == PH_AR2) begin
        ped_pend_next = 1'b0;
      end
    end else if (tick && !expired) begin
      if (is_green && ped_pend_reg && (cnt_reg <= CUT_MAX)) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg - 1'b1;
      end
    end
  end

  assign busy    = (seq_reg == SQ_W0) || (seq_reg == SQ_W1) || (seq_reg == SQ_W2);
  assign lamp_en = (seq_reg == SQ_W1);
  assign phase   = phase_reg;
  assign pattern = phase_pattern(phase_reg);

  // Per-bit set/reset drive: set and reset are complementary and gated by
  // busy, so no bit can ever see both asserted.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_lamp
      assign lamp_s[gi] = busy &  pattern[gi];
      assign lamp_r[gi] = busy & ~pattern[gi];
    end
  endgenerate

endmodule

// File: tb/tb_tl_lamp_sequencer.sv
// Directed bench for tl_lamp_sequencer: reset, free run, pedestrian cut,
// tick-every-clock deferral and reset during the latch strobe.
module tb_tl_lamp_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic [5:0] lamp_s, lamp_r;
  logic       lamp_en, busy;
  logic [2:0] phase;

  int n_checks = 0;
  int n_errors = 0;

  tl_lamp_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .ped_req (ped_req),
    .lamp_s  (lamp_s),
    .lamp_r  (lamp_r),
    .lamp_en (lamp_en),
    .phase   (phase),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tick generator plus per-phase monitor (ticks, clocks, strobes per phase).
  int   tick_mode = 0;
  int   cyc = 0;
  bit   mon_on = 0;
  bit   first_seg = 1;
  logic tick_prev = 1'b0;
  logic [2:0] last_ph = 3'd5;
  int   seg_ticks = 0, seg_clks = 0, seg_en = 0;
  int   q_ph[$], q_tk[$], q_ck[$], q_en[$];

  task automatic mon_start();
    first_seg = 1;
    seg_ticks = 0;
    seg_clks  = 0;
    seg_en    = 0;
    last_ph   = phase;
    q_ph.delete(); q_tk.delete(); q_ck.delete(); q_en.delete();
    mon_on = 1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (tick_prev) seg_ticks++;
        if (phase != last_ph) begin
          if (!first_seg) begin
            q_ph.push_back(int'(last_ph));
            q_tk.push_back(seg_ticks);
            q_ck.push_back(seg_clks);
            q_en.push_back(seg_en);
          end
          first_seg = 0;
          seg_ticks = 0;
          seg_clks  = 0;
          seg_en    = 0;
          last_ph   = phase;
        end
        seg_clks++;
        if (lamp_en) seg_en++;
      end
      cyc++;
      tick = (tick_mode == 2) || (tick_mode == 1 && (cyc % 4) == 0);
      tick_prev = tick;
    end
  end

  // Always-on strobe rules: no set/reset overlap, idle strobes low,
  // one enable per write, enables at least 4 clocks apart.
  logic prev_busy = 1'b0;
  int   en_in_seq = 0;
  int   last_en = -1;
  int   ccyc = 0;
  initial begin
    forever begin
      @(negedge clk);
      ccyc++;
      check_eq("s_and_r_overlap", lamp_s & lamp_r, 0);
      if (!busy) check_eq("idle_strobes", {lamp_s, lamp_r, lamp_en}, 0);
      if (lamp_en) begin
        if (last_en >= 0) check_eq("en_gap_ge4", (ccyc - last_en) >= 4, 1);
        last_en = ccyc;
        en_in_seq++;
      end
      if (!rst_n) en_in_seq = 0;
      else if (prev_busy && !busy) begin
        check_eq("en_per_seq", en_in_seq, 1);
        en_in_seq = 0;
      end
      prev_busy = busy & rst_n;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [2:0] p, input int lim, input string tag);
    int n = 0;
    while (phase !== p && n < lim) begin
      step();
      n++;
    end
    check_eq(tag, phase, p);
  endtask

  task automatic wait_q(input int k, input int lim, input string tag);
    int n = 0;
    while (q_ph.size() < k && n < lim) begin
      step();
      n++;
    end
    check_eq(tag, q_ph.size() >= k, 1);
  endtask

  task automatic check_write_seq(input string tag);
    // Called right after edge T.
    check_eq({tag, "_T_s"}, lamp_s, 6'b001001);
    check_eq({tag, "_T_r"}, lamp_r, 6'b110110);
    check_eq({tag, "_T_en"}, lamp_en, 0);
    check_eq({tag, "_T_busy"}, busy, 1);
    check_eq({tag, "_T_phase"}, phase, 5);
    step();
    check_eq({tag, "_T1_en"}, lamp_en, 1);
    step();
    check_eq({tag, "_T2_en"}, lamp_en, 0);
    check_eq({tag, "_T2_s"}, lamp_s, 6'b001001);
    check_eq({tag, "_T2_r"}, lamp_r, 6'b110110);
    step();
    check_eq({tag, "_T3_strobes"}, {lamp_s, lamp_r, lamp_en}, 0);
    check_eq({tag, "_T3_busy"}, busy, 0);
  endtask

  int exp_run_tk[6] = '{8, 3, 2, 8, 3, 2};
  int exp_ped_tk[4] = '{3, 3, 2, 8};
  int exp_fast_ck[6] = '{9, 4, 4, 9, 4, 4};

  initial begin
    int n;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_lamp_s", lamp_s, 0);
    check_eq("rst_lamp_r", lamp_r, 0);
    check_eq("rst_lamp_en", lamp_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_phase", phase, 5);

    // Release with tick idle: AR2 write, then stay in AR2
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_write_seq("rel");
    repeat (20) step();
    check_eq("idle_phase_stays_ar2", phase, 5);

    // Free run, tick every 4 clocks
    mon_start();
    tick_mode = 1;
    wait_q(6, 2000, "run_timeout");
    for (int i = 0; i < 6 && i < q_ph.size(); i++) begin
      check_eq($sformatf("run_order_%0d", i), q_ph[i], i);
      check_eq($sformatf("run_ticks_ph%0d", i), q_tk[i], exp_run_tk[i]);
      check_eq($sformatf("run_en_ph%0d", i), q_en[i], 1);
    end

    // Pedestrian request one tick into NS_G
    wait_phase(3'd0, 500, "ped_wait_nsg");
    n = 0;
    while (seg_ticks != 1 && n < 100) begin
      step();
      n++;
    end
    check_eq("ped_first_tick", seg_ticks, 1);
    q_ph.delete(); q_tk.delete(); q_ck.delete(); q_en.delete();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check_eq("ped_pend_set", dut.ped_pend_reg, 1);
    wait_phase(3'd2, 500, "ped_wait_ar1");
    check_eq("ped_pend_clr_ar1", dut.ped_pend_reg, 0);
    wait_q(4, 1000, "ped_timeout");
    for (int i = 0; i < 4 && i < q_ph.size(); i++) begin
      check_eq($sformatf("ped_order_%0d", i), q_ph[i], i);
      check_eq($sformatf("ped_ticks_ph%0d", i), q_tk[i], exp_ped_tk[i]);
    end

    // Tick every clock: clock dwell per phase shows deferral during busy
    tick_mode = 2;
    mon_start();
    wait_q(6, 500, "fast_timeout");
    for (int i = 0; i < 6 && i < q_ph.size(); i++) begin
      check_eq($sformatf("fast_clks_ph%0d", q_ph[i]), q_ck[i], exp_fast_ck[q_ph[i]]);
    end

    // Reset dropped while lamp_en is high
    mon_on = 0;
    n = 0;
    while (lamp_en !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check_eq("mid_rst_saw_en", lamp_en, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_strobes", {lamp_s, lamp_r, lamp_en}, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_phase", phase, 5);
    tick_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_write_seq("rerel");

    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tl_lamp_sequencer.md
TL_LAMP_SEQUENCER -- requirements
Module: tl_lamp_sequencer

Interface
REQ-001 Parameter G_TICKS, default 8: green duration, in ticks.
REQ-002 Parameter Y_TICKS, default 3: yellow duration, in ticks.
REQ-003 Parameter R_TICKS, default 2: all-red clearance duration, in ticks.
REQ-004 Parameter MIN_G_TICKS, default 3: minimum green before a pedestrian request may cut green short; MIN_G_TICKS SHALL be less than G_TICKS, and every duration SHALL be at least 1.
REQ-005 The block SHALL use one clock, clk. Reset SHALL be rst_n, asynchronous and active-low.
REQ-006 Ports SHALL be, clock and reset first:
  - clk, in, 1: system clock.
  - rst_n, in, 1: asynchronous active-low reset.
  - tick, in, 1: timebase strobe, one clk wide.
  - ped_req, in, 1: pedestrian request pulse.
  - lamp_s, out, 6: set lines to the six lamp SR latches.
  - lamp_r, out, 6: reset lines to the six lamp SR latches.
  - lamp_en, out, 1: latch enable; the latches capture on its rising edge.
  - phase, out, 3: current phase code.
  - busy, out, 1: latch write sequence in progress.
REQ-007 Lamp bit indices SHALL be: 0 NS_R, 1 NS_Y, 2 NS_G, 3 EW_R, 4 EW_Y, 5 EW_G.

Function
REQ-008 Phases, codes and lamp patterns SHALL be:
  - NS_G=0, pattern 6'b001_100.
  - NS_Y=1, pattern 6'b001_010.
  - AR1=2, pattern 6'b001_001.
  - EW_G=3, pattern 6'b100_001.
  - EW_Y=4, pattern 6'b010_001.
  - AR2=5, pattern 6'b001_001.
REQ-009 Phases SHALL cycle in this order: NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, back to NS_G.
REQ-010 Phase durations SHALL be G_TICKS for green, Y_TICKS for yellow and R_TICKS for all-red.
REQ-011 On phase entry the down-counter SHALL load the phase duration.
REQ-012 Each tick SHALL decrement the counter; it SHALL saturate at 0.
REQ-013 The phase SHALL expire when the counter reaches 0.
REQ-014 A ped_req pulse SHALL set a sticky ped_pend flag.
REQ-015 ped_pend SHALL clear on entry to AR1 or AR2.
REQ-016 In NS_G or EW_G, when ped_pend is 1 and at least MIN_G_TICKS ticks have elapsed in the phase, the phase SHALL expire at the next tick.
REQ-017 Entering any phase SHALL start a latch write sequence. With T the first cycle in the new phase:
  - T: lamp_s=pattern, lamp_r=~pattern, lamp_en=0, busy=1.
  - T+1: lamp_en=1.
  - T+2: lamp_en=0, with lamp_s and lamp_r held.
  - T+3: lamp_s=0, lamp_r=0, busy=0.
REQ-018 A bit SHALL never have lamp_s and lamp_r both 1 in the same cycle.
REQ-019 Outside a write sequence, lamp_s, lamp_r and lamp_en SHALL be 0.
REQ-020 lamp_en SHALL be high for exactly one cycle per sequence.
REQ-021 If a phase expires while busy=1, the transition SHALL be deferred until the first cycle with busy=0.
REQ-022 Ticks arriving during the deferral SHALL be ignored.
REQ-023 ped_req SHALL be captured in every cycle, including while busy=1.
REQ-024 A ped_req arriving in the same cycle as entry to an all-red phase SHALL be dropped.
REQ-025 phase SHALL update in cycle T, the first cycle of the new phase.
REQ-026 phase SHALL be a registered output.

Reset
REQ-027 While rst_n=0, outputs SHALL be: lamp_s=0, lamp_r=0, lamp_en=0, busy=0, phase=5 (AR2).
REQ-028 While rst_n=0, the counter SHALL be R_TICKS and ped_pend SHALL be 0.
REQ-029 The first clk edge after rst_n rises SHALL start a write sequence of the AR2 pattern 6'b001_001, with that edge counted as T.
REQ-030 Reset asserted mid-sequence SHALL immediately force all outputs to their reset values.
REQ-031 No latch write SHALL be issued while rst_n=0.

Verification
REQ-032 Reset release, tick held at 0:
  - T: lamp_s=001001, lamp_r=110110.
  - T+1: lamp_en=1.
  - T+3: all strobes 0.
  - phase stays 5 indefinitely.
REQ-033 Free run with tick every 4 clk and default parameters:
  - phase dwell counts are NS_G 8 ticks, NS_Y 3, AR1 2, EW_G 8, EW_Y 3, AR2 2.
  - exactly one lamp_en pulse per phase.
REQ-034 ped_req one tick after NS_G entry: NS_G ends after exactly 3 ticks, ped_pend clears at AR1, and EW_G runs a full 8 ticks.
REQ-035 Tick every clk, defaults:
  - every expiry during busy is deferred.
  - lamp_en pulses are at least 4 clk apart.
  - lamp_s & lamp_r == 0 in every cycle.
REQ-036 rst_n dropped in the cycle lamp_en=1:
  - outputs are 0 and phase=5 with no clk edge.
  - after release, the AR2 write sequence restarts.
REQ-037 Throughout every scenario, an assertion SHALL check REQ-018, REQ-019 and REQ-020.
